// File: rtl/dram_pkg.sv
// Shared constants and types for the dram word port.
// Line geometry, line register type and FSM states.
package dram_pkg;

    localparam int LINE_BITS = 64 * 8;
    localparam int WORDS     = LINE_BITS / 32;
    localparam int OFS_BITS  = $clog2(WORDS);

    typedef logic [WORDS-1:0][31:0] line_t;

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        MERGE,
        WR_ISSUE,
        WR_WAIT,
        RESP
    } port_state_t;

endpackage

// File: rtl/rdy_settle_timer.sv
// Down-counter that masks dram_*_rdy after a request pulse.
// Loaded with SETTLE, counts to zero, done while zero.
module rdy_settle_timer #(
    parameter int unsigned SETTLE = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic done
);

    localparam int CW = $clog2(SETTLE + 1);

    logic [CW-1:0] cnt_q;

    // Reload on a request pulse, otherwise drain towards zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= CW'(SETTLE);
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/dram_word_port.sv
// Word-to-line front end for the dram block (read-modify-write on writes).
// Optional line buffer: define DRAM_WORD_PORT_LINE_BUF_EN.
module dram_word_port
    import dram_pkg::*;
#(
    parameter int DRAM_ADDR_BITS    = 27,
    parameter int CACHE_BLOCK_BYTES = 64,
    parameter int RDY_SETTLE        = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic                             req_write,
    input  logic [DRAM_ADDR_BITS+OFS_BITS-1:0] req_addr,
    input  logic [31:0]                      req_wdata,
    output logic                             resp_valid,
    output logic [31:0]                      resp_rdata,
    output logic                             dram_read_rq,
    input  logic                             dram_read_rdy,
    input  logic                             dram_read_valid,
    input  logic [CACHE_BLOCK_BYTES*8-1:0]   dram_read_data,
    output logic [DRAM_ADDR_BITS-1:0]        dram_read_addr,
    output logic                             dram_write_rq,
    input  logic                             dram_write_rdy,
    output logic [DRAM_ADDR_BITS-1:0]        dram_write_addr,
    output logic [CACHE_BLOCK_BYTES*8-1:0]   dram_write_data
);

    localparam int AW = DRAM_ADDR_BITS + OFS_BITS;

    port_state_t state_q, state_d;

    logic                      wr_q;
    logic [AW-1:0]             addr_q;
    logic [31:0]               wdata_q;
    line_t                     line_q;
    logic                      rv_q;
    logic                      rv_rise;
    logic                      accept;
    logic                      hit;
    logic                      settle_load;
    logic                      settle_done;
    logic [DRAM_ADDR_BITS-1:0] line_addr;
    logic [OFS_BITS-1:0]       ofs;

    assign line_addr = addr_q[AW-1:OFS_BITS];
    assign ofs       = addr_q[OFS_BITS-1:0];
    assign rv_rise   = dram_read_valid & ~rv_q;
    assign accept    = req_valid && (state_q == IDLE);

`ifdef DRAM_WORD_PORT_LINE_BUF_EN
    logic [DRAM_ADDR_BITS-1:0] tag_q;
    logic                      lvalid_q;

    assign hit = lvalid_q && (tag_q == req_addr[AW-1:OFS_BITS]);

    // Every completed transaction leaves the line register coherent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q    <= '0;
            lvalid_q <= 1'b0;
        end else if (state_q == RESP) begin
            tag_q    <= line_addr;
            lvalid_q <= 1'b1;
        end
    end
`else
    assign hit = 1'b0;
`endif

    rdy_settle_timer #(
        .SETTLE (RDY_SETTLE)
    ) u_settle (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (settle_load),
        .done  (settle_done)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake/request strobes.
    always_comb begin
        state_d       = state_q;
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        dram_read_rq  = 1'b0;
        dram_write_rq = 1'b0;
        settle_load   = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (hit) begin
                        state_d = req_write ? MERGE : RESP;
                    end else begin
                        state_d = RD_ISSUE;
                    end
                end
            end
            RD_ISSUE: begin
                if (dram_read_rdy) begin
                    dram_read_rq = 1'b1;
                    settle_load  = 1'b1;
                    state_d      = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (rv_rise) begin
                    state_d = wr_q ? MERGE : RESP;
                end
            end
            MERGE: begin
                state_d = WR_ISSUE;
            end
            WR_ISSUE: begin
                if (dram_write_rdy && settle_done) begin
                    dram_write_rq = 1'b1;
                    settle_load   = 1'b1;
                    state_d       = WR_WAIT;
                end
            end
            WR_WAIT: begin
                if (settle_done && dram_write_rdy) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Request latch, read-valid edge detector and line register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rv_q    <= 1'b0;
            line_q  <= '0;
        end else begin
            rv_q <= dram_read_valid;
            if (accept) begin
                wr_q    <= req_write;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (state_q == RD_WAIT && rv_rise) begin
                line_q <= dram_read_data;
            end else if (state_q == MERGE) begin
                line_q[ofs] <= wdata_q;
            end
        end
    end

    assign resp_rdata      = (state_q == RESP) ? line_q[ofs] : 32'h0;
    assign dram_read_addr  = line_addr;
    assign dram_write_addr = line_addr;
    assign dram_write_data = line_q;

endmodule
